// File: rtl/ctrl_multiciclo.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/writeback states.
// Outputs decode combinationally from estado (zero latency); memory states stall on mem_ready when MEM_WAIT=1.
module ctrl_multiciclo #(
    parameter int OP_W        = 6,
    parameter int MEM_WAIT    = 0,
    parameter int HALT_RESUME = 0,
    parameter logic [OP_W-1:0] OP_R   = OP_W'(0),
    parameter logic [OP_W-1:0] OP_SW  = OP_W'(6),
    parameter logic [OP_W-1:0] OP_LW  = OP_W'(7),
    parameter logic [OP_W-1:0] OP_BLT = OP_W'(16),
    parameter logic [OP_W-1:0] OP_BGT = OP_W'(32),
    parameter logic [OP_W-1:0] OP_BEQ = OP_W'(48),
    parameter logic [OP_W-1:0] OP_BNE = OP_W'(56),
    parameter logic [OP_W-1:0] OP_JMP = OP_W'(62),
    parameter logic [OP_W-1:0] OP_JAL = OP_W'(60),
    parameter logic [OP_W-1:0] OP_IN  = OP_W'(40),
    parameter logic [OP_W-1:0] OP_OUT = OP_W'(33),
    parameter logic [OP_W-1:0] OP_HLT = OP_W'(63)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            enter,
    input  logic            mem_ready,
    output logic [3:0]      estado,
    output logic            EscrevePC,
    output logic            EscreveRI,
    output logic            EscreveReg,
    output logic            EscreveMem,
    output logic            controleOUT,
    output logic            SelMuxMem,
    output logic            SelMuxReg1,
    output logic            SelMuxReg2,
    output logic            SelMuxUlaA,
    output logic            SelMuxIn,
    output logic [1:0]      SelMuxUlaB,
    output logic [1:0]      SelMuxPC,
    output logic [1:0]      OpULA,
    output logic            busy
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_ADDR   = 4'd2,  S_MEMRD  = 4'd3,
        S_WBMEM  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_WBALU  = 4'd7,
        S_BRCALC = 4'd8,  S_JUMP   = 4'd9,  S_BRUPD  = 4'd10, S_EXI    = 4'd11,
        S_INWAIT = 4'd12, S_JFIN   = 4'd13, S_HALT   = 4'd14, S_INWB   = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   enter_q;
    logic   enter_rise;
    logic   mem_stall;

    // enter_q resets high so a button already held at reset is not taken as a press
    assign enter_rise = enter & ~enter_q;
    assign mem_stall  = (MEM_WAIT != 0) && !mem_ready;
    assign estado     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            enter_q <= 1'b1;
        end else begin
            state_q <= state_d;
            enter_q <= enter;
        end
    end

    always_comb begin
        state_d     = state_q;
        EscrevePC   = 1'b0;
        EscreveRI   = 1'b0;
        EscreveReg  = 1'b0;
        EscreveMem  = 1'b0;
        controleOUT = 1'b0;
        SelMuxMem   = 1'b0;
        SelMuxReg1  = 1'b0;
        SelMuxReg2  = 1'b0;
        SelMuxUlaA  = 1'b0;
        SelMuxIn    = 1'b0;
        SelMuxUlaB  = 2'b00;
        SelMuxPC    = 2'b00;
        OpULA       = 2'b00;
        busy        = (state_q != S_FETCH) && (state_q != S_HALT);

        case (state_q)
            S_FETCH: begin
                EscreveRI  = 1'b1;
                SelMuxUlaB = 2'b01;
                OpULA      = 2'b01;
                SelMuxIn   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                EscrevePC   = (opcode != OP_HLT);
                controleOUT = (opcode == OP_OUT);
                SelMuxUlaB  = 2'b01;
                case (opcode)
                    OP_SW, OP_LW:                   state_d = S_ADDR;
                    OP_R:                           state_d = S_EXR;
                    OP_BLT, OP_BGT, OP_BEQ, OP_BNE: state_d = S_BRCALC;
                    OP_JMP, OP_JAL:                 state_d = S_JUMP;
                    OP_IN:                          state_d = S_INWAIT;
                    OP_OUT:                         state_d = S_FETCH;
                    OP_HLT:                         state_d = S_HALT;
                    default:                        state_d = S_EXI;
                endcase
            end
            S_ADDR: begin
                SelMuxMem  = 1'b1;
                SelMuxUlaA = 1'b1;
                SelMuxUlaB = 2'b11;
                OpULA      = 2'b11;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                SelMuxMem  = 1'b1;
                SelMuxReg2 = 1'b1;
                if (!mem_stall) state_d = S_WBMEM;
            end
            S_WBMEM: begin
                EscreveReg = 1'b1;
                SelMuxMem  = 1'b1;
                SelMuxReg2 = 1'b1;
                state_d    = S_JFIN;
            end
            S_MEMWR: begin
                // write strobe stays up for the whole stall so slow memories see a stable request
                EscreveMem = 1'b1;
                SelMuxMem  = 1'b1;
                SelMuxUlaA = 1'b1;
                OpULA      = 2'b11;
                if (!mem_stall) state_d = S_INWB;
            end
            S_EXR: begin
                SelMuxReg1 = 1'b1;
                SelMuxUlaA = 1'b1;
                state_d    = S_WBALU;
            end
            S_EXI: begin
                SelMuxUlaA = 1'b1;
                SelMuxUlaB = 2'b11;
                state_d    = S_WBALU;
            end
            S_WBALU: begin
                EscreveReg = 1'b1;
                SelMuxUlaA = 1'b1;
                if (opcode == OP_R) begin
                    SelMuxReg1 = 1'b1;
                    SelMuxUlaB = 2'b00;
                end else begin
                    SelMuxUlaB = 2'b11;
                end
                state_d = S_FETCH;
            end
            S_BRCALC: begin
                SelMuxPC   = 2'b01;
                SelMuxUlaA = 1'b1;
                state_d    = S_BRUPD;
            end
            S_BRUPD: begin
                SelMuxPC  = 2'b10;
                OpULA     = 2'b11;
                EscrevePC = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                EscrevePC  = 1'b1;
                SelMuxUlaA = 1'b1;
                SelMuxUlaB = 2'b11;
                OpULA      = 2'b11;
                state_d    = S_JFIN;
            end
            S_JFIN: begin
                EscrevePC  = (opcode == OP_JMP);
                EscreveReg = (opcode == OP_LW);
                SelMuxReg2 = 1'b1;
                state_d    = S_FETCH;
            end
            S_INWAIT: begin
                EscreveReg = 1'b1;
                SelMuxIn   = 1'b1;
                if (enter_rise) state_d = S_INWB;
            end
            S_INWB: begin
                EscreveReg = (opcode != OP_SW);
                SelMuxReg2 = 1'b1;
                SelMuxIn   = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                if ((HALT_RESUME != 0) && enter_rise) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Directed bench: dut0 uses default parameters, dut1 has MEM_WAIT=1 and HALT_RESUME=1.
// Outputs are packed as {PC,RI,Reg,Mem,OUT,MMem,R1,R2,UlaA,In,UlaB[2],PC[2],OpULA[2],busy}.
module tb_ctrl_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero, enter, mem_ready;

    logic [3:0] st [2];
    logic [1:0] pc_w, ri_w, reg_w, mem_w, out_w, mmem_w, r1_w, r2_w, ua_w, in_w, busy_w;
    logic [1:0] ub [2];
    logic [1:0] pcs [2];
    logic [1:0] opu [2];
    logic [16:0] o [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_multiciclo dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .enter(enter), .mem_ready(mem_ready),
        .estado(st[0]), .EscrevePC(pc_w[0]), .EscreveRI(ri_w[0]), .EscreveReg(reg_w[0]),
        .EscreveMem(mem_w[0]), .controleOUT(out_w[0]), .SelMuxMem(mmem_w[0]), .SelMuxReg1(r1_w[0]),
        .SelMuxReg2(r2_w[0]), .SelMuxUlaA(ua_w[0]), .SelMuxIn(in_w[0]), .SelMuxUlaB(ub[0]),
        .SelMuxPC(pcs[0]), .OpULA(opu[0]), .busy(busy_w[0])
    );

    ctrl_multiciclo #(.MEM_WAIT(1), .HALT_RESUME(1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .enter(enter), .mem_ready(mem_ready),
        .estado(st[1]), .EscrevePC(pc_w[1]), .EscreveRI(ri_w[1]), .EscreveReg(reg_w[1]),
        .EscreveMem(mem_w[1]), .controleOUT(out_w[1]), .SelMuxMem(mmem_w[1]), .SelMuxReg1(r1_w[1]),
        .SelMuxReg2(r2_w[1]), .SelMuxUlaA(ua_w[1]), .SelMuxIn(in_w[1]), .SelMuxUlaB(ub[1]),
        .SelMuxPC(pcs[1]), .OpULA(opu[1]), .busy(busy_w[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign o[g] = {pc_w[g], ri_w[g], reg_w[g], mem_w[g], out_w[g], mmem_w[g], r1_w[g],
                       r2_w[g], ua_w[g], in_w[g], ub[g], pcs[g], opu[g], busy_w[g]};
    end

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        en;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic en,
                       input logic mr, input logic [3:0] s, input logic [16:0] out);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.en = en; v.mr = mr; v.st = s; v.out = out;
        vq.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of posedge.
    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic en,
                         input logic mr);
        @(negedge clk);
        rst = r; opcode = op; zero = z; enter = en; mem_ready = mr;
        #1;
    endtask

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    localparam logic [16:0] O_FETCH = 17'h080A2;
    localparam logic [16:0] O_DEC   = 17'h10021;

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; enter = 1'b1; mem_ready = 1'b0;
        @(posedge clk);

        // R-type
        add(1, 0,  0, 1, 0, 0,  O_FETCH);
        add(0, 0,  0, 1, 0, 0,  O_FETCH);
        add(0, 0,  0, 1, 0, 1,  O_DEC);
        add(0, 0,  0, 1, 0, 6,  17'h00501);
        add(0, 0,  0, 1, 0, 7,  17'h04501);
        // immediate (unlisted opcode)
        add(0, 5,  0, 1, 0, 0,  O_FETCH);
        add(0, 5,  0, 1, 0, 1,  O_DEC);
        add(0, 5,  0, 1, 0, 11, 17'h00161);
        add(0, 5,  0, 1, 0, 7,  17'h04161);
        // LW, no memory wait: mem_ready low is ignored
        add(0, 7,  0, 1, 0, 0,  O_FETCH);
        add(0, 7,  0, 1, 0, 1,  O_DEC);
        add(0, 7,  0, 1, 0, 2,  17'h00967);
        add(0, 7,  0, 1, 0, 3,  17'h00A01);
        add(0, 7,  0, 1, 0, 4,  17'h04A01);
        add(0, 7,  0, 1, 0, 13, 17'h04201);
        // SW
        add(0, 6,  0, 1, 0, 0,  O_FETCH);
        add(0, 6,  0, 1, 0, 1,  O_DEC);
        add(0, 6,  0, 1, 0, 2,  17'h00967);
        add(0, 6,  0, 1, 0, 5,  17'h02907);
        add(0, 6,  0, 1, 0, 15, 17'h00281);
        // BEQ not taken, then taken
        add(0, 48, 0, 1, 0, 0,  O_FETCH);
        add(0, 48, 0, 1, 0, 1,  O_DEC);
        add(0, 48, 0, 1, 0, 8,  17'h00109);
        add(0, 48, 0, 1, 0, 10, 17'h00017);
        add(0, 48, 1, 1, 0, 0,  O_FETCH);
        add(0, 48, 1, 1, 0, 1,  O_DEC);
        add(0, 48, 1, 1, 0, 8,  17'h00109);
        add(0, 48, 1, 1, 0, 10, 17'h10017);
        // JMP, JAL
        add(0, 62, 0, 1, 0, 0,  O_FETCH);
        add(0, 62, 0, 1, 0, 1,  O_DEC);
        add(0, 62, 0, 1, 0, 9,  17'h10167);
        add(0, 62, 0, 1, 0, 13, 17'h10201);
        add(0, 60, 0, 1, 0, 0,  O_FETCH);
        add(0, 60, 0, 1, 0, 1,  O_DEC);
        add(0, 60, 0, 1, 0, 9,  17'h10167);
        add(0, 60, 0, 1, 0, 13, 17'h00201);
        // OUT
        add(0, 33, 0, 1, 0, 0,  O_FETCH);
        add(0, 33, 0, 1, 0, 1,  17'h11021);
        // IN: enter high since reset must not count; a low-then-high does
        add(0, 40, 0, 1, 0, 0,  O_FETCH);
        add(0, 40, 0, 1, 0, 1,  O_DEC);
        add(0, 40, 0, 1, 0, 12, 17'h04081);
        add(0, 40, 0, 1, 0, 12, 17'h04081);
        add(0, 40, 0, 0, 0, 12, 17'h04081);
        add(0, 40, 0, 1, 0, 12, 17'h04081);
        add(0, 40, 0, 1, 0, 15, 17'h04281);
        add(0, 63, 0, 1, 0, 0,  O_FETCH);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].op, vq[i].z, vq[i].en, vq[i].mr);
            chk($sformatf("vec%0d estado", i), {13'd0, st[0]}, {13'd0, vq[i].st});
            chk($sformatf("vec%0d outputs", i), o[0], vq[i].out);
        end

        // HLT on dut0: no resume, enter toggling
        drive(0, 63, 0, 1, 0);
        chk("hlt decode", o[0], 17'h00021);
        for (int i = 0; i < 22; i++) begin
            drive(0, 63, 0, (i % 2) == 0 ? 1'b0 : 1'b1, 0);
            chk($sformatf("halt%0d estado", i), {13'd0, st[0]}, 17'd14);
            chk($sformatf("halt%0d outputs", i), o[0], 17'h0);
        end

        // dut1: LW with three stall cycles
        drive(1, 7, 0, 0, 0);
        drive(0, 7, 0, 0, 0);
        chk("lw_wait fetch", {13'd0, st[1]}, 17'd0);
        drive(0, 7, 0, 0, 0);
        chk("lw_wait decode", {13'd0, st[1]}, 17'd1);
        drive(0, 7, 0, 0, 0);
        chk("lw_wait addr", {13'd0, st[1]}, 17'd2);
        for (int i = 0; i < 4; i++) begin
            drive(0, 7, 0, 0, (i == 3) ? 1'b1 : 1'b0);
            chk($sformatf("lw_wait memrd%0d", i), {13'd0, st[1]}, 17'd3);
        end
        drive(0, 7, 0, 0, 0);
        chk("lw_wait wbmem", {13'd0, st[1]}, 17'd4);
        drive(0, 7, 0, 0, 0);
        chk("lw_wait jfin", {13'd0, st[1]}, 17'd13);
        drive(0, 6, 0, 0, 0);
        chk("lw_wait back", {13'd0, st[1]}, 17'd0);

        // dut1: SW stalled, then reset mid-stall
        drive(0, 6, 0, 0, 0);
        drive(0, 6, 0, 0, 0);
        chk("sw_wait addr", {13'd0, st[1]}, 17'd2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 6, 0, 0, 0);
            chk($sformatf("sw_wait memwr%0d estado", i), {13'd0, st[1]}, 17'd5);
            chk($sformatf("sw_wait memwr%0d EscreveMem", i), {16'd0, mem_w[1]}, 17'd1);
        end
        drive(1, 6, 0, 1, 0);
        chk("sw_rst pre estado", {13'd0, st[1]}, 17'd5);
        drive(0, 63, 0, 1, 0);
        chk("sw_rst estado", {13'd0, st[1]}, 17'd0);
        chk("sw_rst outputs", o[1], O_FETCH);

        // dut1: HLT with resume on an enter edge
        drive(0, 63, 0, 1, 0);
        chk("resume decode", {13'd0, st[1]}, 17'd1);
        drive(0, 63, 0, 1, 0);
        chk("resume halt held", {13'd0, st[1]}, 17'd14);
        drive(0, 63, 0, 0, 0);
        chk("resume halt low", {13'd0, st[1]}, 17'd14);
        drive(0, 63, 0, 1, 0);
        chk("resume halt edge", {13'd0, st[1]}, 17'd14);
        drive(0, 63, 0, 1, 0);
        chk("resume fetch", {13'd0, st[1]}, 17'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
